// File: rtl/video_effects_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : video_effects_ctrl_if
// Purpose  : Avalon-MM register-bus bundle for video_effects_ctrl
//            (read latency 1)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface video_effects_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write,
    input  writedata,
    input  read,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write,
    output writedata,
    output read,
    input  readdata
  );
endinterface
`default_nettype wire

// File: rtl/video_effects_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : video_effects_ctrl
// Purpose  : Shadow/active configuration registers for video_effects with
//            end-of-frame atomic commit, frame counter, frame interrupt and
//            automatic effect-cycling demo mode.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module video_effects_ctrl #(
  parameter int CNT_W = 16
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  video_effects_ctrl_if.slave     bus,
  input  wire logic               stream_valid,
  input  wire logic               stream_ready,
  input  wire logic               stream_sop,
  input  wire logic               stream_eop,
  output logic [4:0]              effect,
  output logic [1:0]              effect_delete_rgb,
  output logic [1:0]              effect_quantif_level,
  output logic [15:0]             effect_color_key,
  output logic [15:0]             effect_color_key_threshold,
  output logic [15:0]             effect_color_substitute,
  output logic                    frame_irq
);

  localparam logic [2:0] c_ADDR_CONTROL = 3'd0;
  localparam logic [2:0] c_ADDR_KEY     = 3'd1;
  localparam logic [2:0] c_ADDR_THRESH  = 3'd2;
  localparam logic [2:0] c_ADDR_SUBST   = 3'd3;
  localparam logic [2:0] c_ADDR_COMMIT  = 3'd4;
  localparam logic [2:0] c_ADDR_STATUS  = 3'd5;
  localparam logic [2:0] c_ADDR_PERIOD  = 3'd6;
  localparam logic [2:0] c_LAST_STEP    = 3'd5;

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  // Shadow (software-visible) settings
  logic [4:0]  r_sh_effect;
  logic [1:0]  r_sh_delete;
  logic [1:0]  r_sh_quant;
  logic        r_sh_auto;
  logic        r_sh_irq_en;
  logic [15:0] r_sh_key;
  logic [15:0] r_sh_thresh;
  logic [15:0] r_sh_subst;
  logic [7:0]  r_period;
  logic        r_commit_pending;

  // Active settings driving the datapath
  logic [4:0]  r_act_effect;

  logic [CNT_W-1:0] r_frame_cnt;
  logic [7:0]  r_sub_cnt;
  logic [2:0]  r_step;
  state_t      r_state;
  logic        r_irq;
  logic [31:0] r_readdata;

  logic        w_wr;
  logic        w_rd;
  logic        w_eof;
  logic        w_commit_now;
  logic [7:0]  w_period_eff;
  logic [15:0] w_cnt16;
  logic [4:0]  w_step_pattern;
  logic [31:0] w_rdata;
  state_t      w_state_nxt;
  logic [2:0]  w_step_nxt;
  logic [7:0]  w_sub_nxt;
  logic        w_unused;

  assign w_wr         = bus.chipselect & bus.write;
  assign w_rd         = bus.chipselect & bus.read;
  assign w_eof        = stream_valid & stream_ready & stream_eop;
  // A commit is applied only with the pending flag as it stood before this
  // edge, so a COMMIT write coinciding with eof waits for the next frame.
  assign w_commit_now = w_eof & r_commit_pending;
  assign w_period_eff = (r_period == 8'd0) ? 8'd1 : r_period;
  assign w_cnt16      = 16'(r_frame_cnt);
  assign frame_irq    = r_irq;
  assign bus.readdata = r_readdata;

  // SOP is informational only; upper write-data bits have no storage.
  assign w_unused = ^{stream_sop, bus.writedata[31:18]};

  // Software writes to shadow registers and the PERIOD register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_effect <= 5'd0;
      r_sh_delete <= 2'd0;
      r_sh_quant  <= 2'd0;
      r_sh_auto   <= 1'b0;
      r_sh_irq_en <= 1'b0;
      r_sh_key    <= 16'd0;
      r_sh_thresh <= 16'd0;
      r_sh_subst  <= 16'd0;
      r_period    <= 8'd1;
    end else if (w_wr) begin
      case (bus.address)
        c_ADDR_CONTROL: begin
          r_sh_effect <= bus.writedata[4:0];
          r_sh_delete <= bus.writedata[6:5];
          r_sh_quant  <= bus.writedata[8:7];
          r_sh_auto   <= bus.writedata[16];
          r_sh_irq_en <= bus.writedata[17];
        end
        c_ADDR_KEY:    r_sh_key    <= bus.writedata[15:0];
        c_ADDR_THRESH: r_sh_thresh <= bus.writedata[15:0];
        c_ADDR_SUBST:  r_sh_subst  <= bus.writedata[15:0];
        c_ADDR_PERIOD: r_period    <= bus.writedata[7:0];
        default: ;
      endcase
    end
  end

  // Commit request: a new COMMIT write wins over the clear at eof
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_commit_pending <= 1'b0;
    end else if (w_wr && bus.address == c_ADDR_COMMIT) begin
      r_commit_pending <= 1'b1;
    end else if (w_eof) begin
      r_commit_pending <= 1'b0;
    end
  end

  // Active registers copy the pre-write shadow values at a committing eof
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_effect               <= 5'd0;
      effect_delete_rgb          <= 2'd0;
      effect_quantif_level       <= 2'd0;
      effect_color_key           <= 16'd0;
      effect_color_key_threshold <= 16'd0;
      effect_color_substitute    <= 16'd0;
    end else if (w_commit_now) begin
      r_act_effect               <= r_sh_effect;
      effect_delete_rgb          <= r_sh_delete;
      effect_quantif_level       <= r_sh_quant;
      effect_color_key           <= r_sh_key;
      effect_color_key_threshold <= r_sh_thresh;
      effect_color_substitute    <= r_sh_subst;
    end
  end

  // Free-running frame counter, wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
    end else if (w_eof) begin
      r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  // Frame interrupt: set at eof has priority over a software clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else if (w_eof && r_sh_irq_en) begin
      r_irq <= 1'b1;
    end else if (w_wr && bus.address == c_ADDR_STATUS && bus.writedata[16]) begin
      r_irq <= 1'b0;
    end
  end

  // Mode state, auto step index and frame sub-counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_MANUAL;
      r_step    <= 3'd0;
      r_sub_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_sub_cnt <= w_sub_nxt;
    end
  end

  // One-hot walking pattern for the demo sequence, ending in all-off
  always_comb begin
    w_step_pattern = 5'b00000;
    case (r_step)
      3'd0: w_step_pattern = 5'b00001;
      3'd1: w_step_pattern = 5'b00010;
      3'd2: w_step_pattern = 5'b00100;
      3'd3: w_step_pattern = 5'b01000;
      3'd4: w_step_pattern = 5'b10000;
      default: w_step_pattern = 5'b00000;
    endcase
  end

  // Mode transitions, auto stepping and effect output selection
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_sub_nxt   = r_sub_cnt;
    effect      = r_act_effect;
    case (r_state)
      ST_MANUAL: begin
        if (w_commit_now && r_sh_auto) begin
          w_state_nxt = ST_AUTO;
          w_step_nxt  = 3'd0;
          w_sub_nxt   = 8'd0;
        end
      end
      ST_AUTO: begin
        effect = w_step_pattern;
        if (w_commit_now && !r_sh_auto) begin
          w_state_nxt = ST_MANUAL;
          w_step_nxt  = 3'd0;
          w_sub_nxt   = 8'd0;
        end else if (w_eof) begin
          // >= keeps the counter bounded if PERIOD is lowered mid-count
          if ({1'b0, r_sub_cnt} + 9'd1 >= {1'b0, w_period_eff}) begin
            w_sub_nxt  = 8'd0;
            w_step_nxt = (r_step >= c_LAST_STEP) ? 3'd0 : r_step + 3'd1;
          end else begin
            w_sub_nxt = r_sub_cnt + 8'd1;
          end
        end
      end
    endcase
  end

  // Read-data multiplexer; reserved bits and unmapped addresses read 0
  always_comb begin
    w_rdata = 32'd0;
    case (bus.address)
      c_ADDR_CONTROL: w_rdata = {14'd0, r_sh_irq_en, r_sh_auto, 7'd0,
                                 r_sh_quant, r_sh_delete, r_sh_effect};
      c_ADDR_KEY:     w_rdata = {16'd0, r_sh_key};
      c_ADDR_THRESH:  w_rdata = {16'd0, r_sh_thresh};
      c_ADDR_SUBST:   w_rdata = {16'd0, r_sh_subst};
      c_ADDR_COMMIT:  w_rdata = {31'd0, r_commit_pending};
      c_ADDR_STATUS:  w_rdata = {15'd0, r_irq, w_cnt16};
      c_ADDR_PERIOD:  w_rdata = {24'd0, r_period};
      default:        w_rdata = 32'd0;
    endcase
  end

  // Registered read data, one cycle after the read strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else if (w_rd) begin
      r_readdata <= w_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_effects_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_video_effects_ctrl
// Purpose  : Directed self-checking bench for video_effects_ctrl
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_video_effects_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stream_valid, stream_ready, stream_sop, stream_eop;
  logic [4:0]  effect;
  logic [1:0]  effect_delete_rgb, effect_quantif_level;
  logic [15:0] effect_color_key, effect_color_key_threshold, effect_color_substitute;
  logic        frame_irq;
  logic [31:0] rdat;

  int checks   = 0;
  int failures = 0;

  video_effects_ctrl_if bus_if ();

  video_effects_ctrl #(.CNT_W(16)) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .bus                        (bus_if),
    .stream_valid               (stream_valid),
    .stream_ready               (stream_ready),
    .stream_sop                 (stream_sop),
    .stream_eop                 (stream_eop),
    .effect                     (effect),
    .effect_delete_rgb          (effect_delete_rgb),
    .effect_quantif_level       (effect_quantif_level),
    .effect_color_key           (effect_color_key),
    .effect_color_key_threshold (effect_color_key_threshold),
    .effect_color_substitute    (effect_color_substitute),
    .frame_irq                  (frame_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock of optional register write and optional eof beat
  task automatic cycle(input logic wr, input logic [2:0] a, input logic [31:0] d, input logic eof);
    bus_if.chipselect = wr;
    bus_if.write      = wr;
    bus_if.address    = a;
    bus_if.writedata  = d;
    stream_valid      = eof;
    stream_ready      = eof;
    stream_eop        = eof;
    @(posedge clk);
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
    stream_valid      = 1'b0;
    stream_ready      = 1'b0;
    stream_eop        = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(1'b1, a, d, 1'b0);
  endtask

  task automatic eof();
    cycle(1'b0, 3'd0, 32'd0, 1'b1);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    bus_if.address    = a;
    @(posedge clk);
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
    d = bus_if.readdata;
  endtask

  function automatic logic [4:0] pat(input int step);
    case (step % 6)
      0: return 5'b00001;
      1: return 5'b00010;
      2: return 5'b00100;
      3: return 5'b01000;
      4: return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  initial begin
    reset_n = 1'b1;
    bus_if.chipselect = 1'b0; bus_if.write = 1'b0; bus_if.read = 1'b0;
    bus_if.address = 3'd0; bus_if.writedata = 32'd0;
    stream_valid = 1'b0; stream_ready = 1'b0; stream_sop = 1'b0; stream_eop = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_effect", {27'd0, effect}, 32'd0);
    check("rst_irq", {31'd0, frame_irq}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    rd(3'd6, rdat); check("rst_period", rdat, 32'd1);
    rd(3'd5, rdat); check("rst_status", rdat, 32'd0);

    // Atomic commit
    wr(3'd0, 32'h10);
    wr(3'd4, 32'h0);
    check("commit_no_eof_effect", {27'd0, effect}, 32'd0);
    rd(3'd4, rdat); check("commit_pending_set", rdat, 32'd1);
    eof();
    check("commit_eof_effect", {27'd0, effect}, 32'h10);
    rd(3'd4, rdat); check("commit_pending_clr", rdat, 32'd0);

    // COMMIT write in the same cycle as eof
    wr(3'd0, 32'h03);
    cycle(1'b1, 3'd4, 32'h0, 1'b1);
    check("same_cycle_commit_effect", {27'd0, effect}, 32'h10);
    rd(3'd4, rdat); check("same_cycle_pending", rdat, 32'd1);
    eof();
    check("second_eof_effect", {27'd0, effect}, 32'h03);

    // Shadow write coinciding with a committing eof
    wr(3'd1, 32'h1234);
    wr(3'd2, 32'h5555);
    wr(3'd3, 32'h0F0F);
    wr(3'd4, 32'h0);
    eof();
    check("key_first", {16'd0, effect_color_key}, 32'h1234);
    check("thresh", {16'd0, effect_color_key_threshold}, 32'h5555);
    check("subst", {16'd0, effect_color_substitute}, 32'h0F0F);
    wr(3'd4, 32'h0);
    cycle(1'b1, 3'd1, 32'hABCD, 1'b1);
    check("key_prewrite", {16'd0, effect_color_key}, 32'h1234);
    rd(3'd1, rdat); check("key_shadow", rdat, 32'hABCD);
    wr(3'd4, 32'h0);
    eof();
    check("key_second", {16'd0, effect_color_key}, 32'hABCD);

    // IRQ and counter (6 eofs so far)
    wr(3'd0, 32'h20003);
    eof();
    check("irq_set", {31'd0, frame_irq}, 32'd1);
    rd(3'd5, rdat); check("status_7", rdat, 32'h10007);
    wr(3'd5, 32'h10000);
    check("irq_clear", {31'd0, frame_irq}, 32'd0);
    cycle(1'b1, 3'd5, 32'h10000, 1'b1);
    check("irq_set_wins", {31'd0, frame_irq}, 32'd1);
    stream_valid = 1'b1; stream_eop = 1'b1; stream_ready = 1'b0;
    @(negedge clk);
    stream_valid = 1'b0; stream_ready = 1'b1;
    @(negedge clk);
    stream_eop = 1'b0; stream_ready = 1'b0;
    rd(3'd5, rdat); check("stall_no_count", rdat, 32'h10008);

    // AUTO sequencing with PERIOD=2
    wr(3'd6, 32'd2);
    wr(3'd0, 32'h30003);
    wr(3'd4, 32'h0);
    eof();
    check("auto_enter", {27'd0, effect}, {27'd0, pat(0)});
    rd(3'd0, rdat); check("control_rb", rdat, 32'h30003);
    for (int i = 1; i <= 12; i++) begin
      eof();
      check($sformatf("auto_p2_eof%0d", i), {27'd0, effect}, {27'd0, pat(i / 2)});
    end
    wr(3'd6, 32'd0);
    eof();
    check("auto_p0_a", {27'd0, effect}, {27'd0, pat(1)});
    wr(3'd4, 32'h0);
    eof();
    check("auto_commit_keep", {27'd0, effect}, {27'd0, pat(2)});
    check("auto_delete_active", {30'd0, effect_delete_rgb}, 32'd0);
    rd(3'd5, rdat); check("status_23", rdat, 32'h10017);

    // Asynchronous reset mid-frame
    stream_valid = 1'b1; stream_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("arst_effect", {27'd0, effect}, 32'd0);
    check("arst_key", {16'd0, effect_color_key}, 32'd0);
    check("arst_thresh", {16'd0, effect_color_key_threshold}, 32'd0);
    check("arst_irq", {31'd0, frame_irq}, 32'd0);
    check("arst_readdata", bus_if.readdata, 32'd0);
    @(negedge clk);
    stream_valid = 1'b0; stream_ready = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    rd(3'd6, rdat); check("arst_period", rdat, 32'd1);
    rd(3'd0, rdat); check("arst_control", rdat, 32'd0);
    rd(3'd4, rdat); check("arst_commit", rdat, 32'd0);
    rd(3'd5, rdat); check("arst_status", rdat, 32'd0);

    // Counter wrap after 65536 frames
    stream_valid = 1'b1; stream_ready = 1'b1; stream_eop = 1'b1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    stream_valid = 1'b0; stream_ready = 1'b0; stream_eop = 1'b0;
    rd(3'd5, rdat); check("cnt_wrap", rdat, 32'd0);
    eof();
    rd(3'd5, rdat); check("cnt_after_wrap", rdat, 32'd1);
    rd(3'd7, rdat); check("addr7_zero", rdat, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_effects_ctrl.md
# video_effects_ctrl

Configuration controller for the `video_effects` pixel datapath. It exposes an Avalon-MM slave register bank to the Nios II processor and holds all effect settings in shadow registers. It copies them into the active registers that drive `video_effects` only at an end-of-frame beat, so a frame is never processed with mixed settings. It also provides a frame counter, an end-of-frame interrupt, and an automatic effect-cycling demo mode.

## Interface
Parameters:
- `CNT_W`, 16, width of the frame counter

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `address`  in  3  Avalon-MM word address
- `chipselect`  in  1  Avalon-MM select
- `write`  in  1  write strobe
- `writedata`  in  32  write data
- `read`  in  1  read strobe
- `readdata`  out  32  read data, read latency 1
- `stream_valid`, `stream_ready`, `stream_sop`, `stream_eop`  in  1 each  monitored Avalon-ST handshake at the `video_effects` input
- `effect`  out  5  active effect enables
- `effect_delete_rgb`  out  2  active RGB delete select
- `effect_quantif_level`  out  2  active quantisation level
- `effect_color_key`, `effect_color_key_threshold`, `effect_color_substitute`  out  16 each  active chroma-key settings
- `frame_irq`  out  1  level interrupt

## Operation
- Register write: `chipselect & write`. Register read: `chipselect & read`, with `readdata` valid on the next cycle. Reserved bits and address 7 read 0.
- Register map:
  - 0 CONTROL (shadow): [4:0] effect, [6:5] delete_rgb, [8:7] quantif_level, [16] auto_cycle, [17] irq_en.
  - 1 KEY (shadow): [15:0].
  - 2 THRESHOLD (shadow): [15:0].
  - 3 SUBST (shadow): [15:0].
  - 4 COMMIT:
    - Write: any value sets `commit_pending`.
    - Read: [0] = `commit_pending`.
  - 5 STATUS:
    - Read: [15:0] = frame count, [16] = `frame_irq`.
    - Write: a 1 in bit 16 clears `frame_irq`.
  - 6 PERIOD: [7:0] frames per auto step. Reset value 1. A value of 0 behaves as 1.
- Frame end (`eof`): `stream_valid & stream_ready & stream_eop`. `stream_sop` is read-only status and does not affect behaviour.
- On `eof`:
  - The frame counter increments.
  - If `commit_pending` is set: all active registers load from shadow, including the active auto_cycle bit, and `commit_pending` clears.
  - If shadow irq_en = 1: `frame_irq` sets.
- State machine:
  - MANUAL (reset state): `effect` = active effect.
  - AUTO: `effect` = step pattern. The steps, in order, are 00001, 00010, 00100, 01000, 10000, 00000. After 00000 the sequence wraps to 00001.
  - In AUTO, every other output still comes from the active registers.
  - MANUAL→AUTO on a commit with auto_cycle = 1. Step index and frame sub-counter are reset to 0.
  - AUTO→MANUAL on a commit with auto_cycle = 0.
  - In AUTO, on each `eof` the sub-counter increments. When it reaches max(PERIOD,1), it clears and the step advances.
  - A commit that keeps AUTO resets neither the step nor the sub-counter.
- Arithmetic:
  - Frame counter: `CNT_W` bits, wraps 0xFFFF→0x0000.
  - Sub-counter: 8 bits.
  - Step index: 0–5.

## Timing
- Active outputs change on the clock edge that samples `eof`, so the first beat after `eof` sees the new settings.
- AUTO step advance happens on the same edge.
- Simultaneous events:
  - COMMIT write in the same cycle as `eof`: not applied at that `eof`. `commit_pending` is set after the edge and applies at the next `eof`.
  - Shadow register write in the same cycle as a committing `eof`: the active register receives the pre-write shadow value. The shadow register takes the new value.
  - STATUS clear in the same cycle as an irq set: set wins and `frame_irq` stays 1.
- Reset (async assert, any time, including mid-frame):
  - All active outputs, shadow registers, `commit_pending`, the counters, `frame_irq` and `readdata` go to 0. PERIOD goes to 1. The state machine goes to MANUAL.
  - Deassertion takes effect at the next clock edge.
- Stall: `eof` requires `stream_ready`. A held EOP beat with `stream_ready = 0` produces no event.

## Test plan
- Atomic commit:
  - Write CONTROL=0x10, then COMMIT, with no `eof`: `effect` stays 0.
  - Then one `eof`: `effect` = 10000 from the next cycle, and COMMIT reads 0.
- Same-cycle COMMIT write and `eof`: `effect` is unchanged after that edge and updates after the second `eof`.
- Shadow write during commit:
  - KEY=0x1234 committed. KEY=0xABCD written in the same cycle as the committing `eof`: `effect_color_key` = 0x1234.
  - After a second COMMIT and `eof`: `effect_color_key` = 0xABCD.
- AUTO sequencing:
  - Commit CONTROL bit16 = 1 with PERIOD=2, then 12 `eof` events.
  - `effect` sequence is 00001,00001,00010,00010,00100,00100,01000,01000,10000,10000,00000,00000, then wraps to 00001.
  - With PERIOD=0, the step advances on every `eof`.
- IRQ and counter:
  - irq_en = 1, one `eof`: `frame_irq` = 1, STATUS[15:0] = 1.
  - STATUS write 0x10000 with no `eof`: `frame_irq` = 0.
  - STATUS clear in the same cycle as an `eof`: `frame_irq` stays 1.
  - 65536 `eof` events: count wraps to 0.
- Reset mid-frame:
  - Assert `reset_n` = 0 asynchronously in AUTO with `effect` = 00100: all outputs read 0 immediately and PERIOD reads 1.
  - Stalled EOP beat (`stream_ready` = 0): no count increment.
